fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the multicycle core: holds the architectural PC, fetches one instruction word from instruction memory over a request/grant/response handshake, and presents it to decode with a valid/ready handshake. It sits directly upstream of decode and directly downstream of `sequencer`. It consumes the resolved `npc` and supplies `pc_plus4` as the sequencer's not-taken target. Exactly one instruction is in flight at a time; no speculation.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `imem_req`  out  1  fetch request; held until granted
- `imem_addr`  out  32  fetch address, always equal to `pc`
- `imem_gnt`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched instruction word
- `inst_valid`  out  1  `inst`/`pc` valid for decode
- `inst_ready`  in  1  decode accepts instruction
- `inst`  out  32  registered instruction word
- `pc`  out  32  address of current instruction
- `pc_plus4`  out  32  `pc + 4`, feeds sequencer `notbranch`
- `npc_valid`  in  1  execute presents resolved next PC
- `npc`  in  32  next PC from `sequencer`
- `misalign_err`  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- States: FETCH, WAIT, ISSUE, EXEC, ERR (ERR only with macro).
- Reset values: state=FETCH, `pc`=RESET_PC, `inst`=0, `inst_valid`=0, `misalign_err`=0. `imem_req`=1 in the first cycle after deassertion.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. If `imem_gnt`=1, go to WAIT. Otherwise stay, with the request and address held stable.
- WAIT: `imem_req`=0. If `imem_rvalid`=1, capture `imem_rdata` into `inst` and go to ISSUE.
- ISSUE: `inst_valid`=1. `inst` and `pc` are held stable until `inst_valid && inst_ready`, then go to EXEC.
- EXEC: `inst_valid`=0. If `npc_valid`=1, load `pc` from `npc` and go to FETCH.
- `npc_valid` outside EXEC is ignored. `imem_rvalid` outside WAIT is ignored and its data is dropped.
- `imem_gnt` outside FETCH is ignored.
- `pc_plus4` is combinational `pc + 32'd4`, truncated to 32 bits. `pc`=32'hFFFF_FFFC gives 32'h0000_0000.
- `inst_valid` and `imem_req` are decoded from registered state only; no combinational path from inputs.

## Timing
- Grant in cycle t: `imem_rvalid` is legal from cycle t+1. Same-cycle grant and response is not supported.
- Response in cycle r: `inst_valid`=1 from cycle r+1.
- Decode accepts in cycle a: `inst_valid`=0 from cycle a+1.
- `npc_valid` in cycle u: new `pc` and `imem_req`=1 from cycle u+1.
- Minimum instruction period with zero-wait memory and an immediate `npc_valid`: 4 cycles (FETCH, WAIT, ISSUE, EXEC).
- Reset asserted mid-operation: all state and outputs return to reset values immediately, without waiting for a clock edge. An outstanding memory response arriving after reset is ignored because the block is in FETCH.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - On `npc_valid` in EXEC with `npc[1:0]`≠0, load `pc`=`npc` unmodified, set `misalign_err`=1 and go to ERR.
  - In ERR: `imem_req`=0 and `inst_valid`=0. ERR is left only by reset.
- Not defined:
  - On `npc_valid`, load `pc`={`npc[31:2]`,2'b00}.
  - ERR does not exist and `misalign_err` is tied to 0.

## Test plan
- Reset, then zero-wait memory returning 32'h00A00093 for addr 0 -> `imem_addr`=0, `inst_valid`=1 two cycles after grant, `pc`=0, `pc_plus4`=4.
- Hold `imem_gnt`=0 for 3 cycles -> `imem_req` and `imem_addr` stable all 3 cycles; exactly one WAIT entry after the grant.
- Hold `inst_ready`=0 for 5 cycles in ISSUE -> `inst`/`pc` unchanged, `inst_valid` stays 1; deasserts the cycle after acceptance.
- In EXEC, `npc_valid` with `npc`=32'hAABBCCDC -> next cycle `imem_addr`=32'hAABBCCDC, `pc_plus4`=32'hAABBCCE0. Repeat with `pc`=32'hFFFFFFFC -> `pc_plus4`=0.
- `npc`=32'hAABBCCDD: with macro -> `misalign_err`=1, `imem_req` stays 0 until reset; without macro -> fetch from 32'hAABBCCDC.
- Assert `rst_n`=0 while in WAIT, then deliver `imem_rvalid` after release -> response dropped, `pc`=RESET_PC, `imem_req`=1.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus bundle: imem request/grant/response, decode valid/ready, next-PC
//
// Purpose : groups every non-clock/reset signal of fetch_unit into one bundle.
// Modports:
//   master - fetch_unit side: drives imem_req/imem_addr, inst_valid/inst/pc/pc_plus4,
//            misalign_err; samples imem_gnt/imem_rvalid/imem_rdata, inst_ready,
//            npc_valid/npc.
//   slave  - environment side (imem, decode, sequencer): the mirror image.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        npc_valid;
  logic [31:0] npc;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, pc, pc_plus4, misalign_err,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, npc_valid, npc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, pc, pc_plus4, misalign_err,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, npc_valid, npc
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: one instruction in flight, FETCH/WAIT/ISSUE/EXEC
//
// Purpose : holds the architectural PC, fetches one word from instruction memory
//           over req/gnt/rvalid, presents it to decode over valid/ready, then waits
//           for the resolved next PC from the sequencer.
// Ports   :
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   bus          master modport of fetch_unit_if:
//     imem_req/imem_addr out, imem_gnt/imem_rvalid/imem_rdata in
//     inst_valid/inst/pc/pc_plus4 out, inst_ready in
//     npc_valid/npc in, misalign_err out
// Config  : FETCH_MISALIGN_TRAP_EN - when defined, a misaligned next PC is loaded
//           unmodified, sets sticky misalign_err and parks the block in ERR until
//           reset. When undefined the low two bits of npc are cleared and
//           misalign_err is tied to 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    WAIT  = 3'd1,
    ISSUE = 3'd2,
    EXEC  = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    ERR   = 3'd4
`endif
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  // req/valid are registered alongside the state so no input reaches them combinationally.
  logic        req_q;
  logic        valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.imem_gnt) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            inst_q  <= bus.imem_rdata;
            state_q <= ISSUE;
            valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.inst_ready) begin
            state_q <= EXEC;
            valid_q <= 1'b0;
          end
        end
        EXEC: begin
          if (bus.npc_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_q <= bus.npc;
            if (bus.npc[1:0] != 2'b00) begin
              err_q   <= 1'b1;
              state_q <= ERR;
            end else begin
              state_q <= FETCH;
              req_q   <= 1'b1;
            end
`else
            pc_q    <= {bus.npc[31:2], 2'b00};
            state_q <= FETCH;
            req_q   <= 1'b1;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        ERR: begin
          // Terminal until reset; req/valid already low on entry.
          state_q <= ERR;
        end
`endif
        default: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_q + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.misalign_err = err_q;
`else
  assign bus.misalign_err = 1'b0;
`endif

endmodule
